// File: rtl/count_pkg.sv
// Shared types and constants for the 2-bit up/down counter receive path.
package count_pkg;

  typedef logic [1:0] cnt_state_t;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN,
    ILLEGAL
  } step_cls_t;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } fsm_state_t;

  localparam int unsigned ERR_CNT_W   = 4;
  localparam logic [3:0]  ERR_CNT_MAX = 4'd15;

endpackage

// File: rtl/step_classify.sv
// Maps a (previous, current) counter sample pair to a step class.
module step_classify
  import count_pkg::*;
(
  input  cnt_state_t i_prev,
  input  cnt_state_t i_cur,
  output step_cls_t  o_cls_c
);

  logic [1:0] w_delta;

  // Modulo-4 difference: +1 is up, -1 (3) is down, 2 is an impossible jump.
  assign w_delta = 2'(i_cur - i_prev);

  always_comb begin
    o_cls_c = HOLD;
    case (w_delta)
      2'd1:    o_cls_c = UP;
      2'd2:    o_cls_c = ILLEGAL;
      2'd3:    o_cls_c = DOWN;
      default: o_cls_c = HOLD;
    endcase
  end

endmodule

// File: rtl/count_decoder.sv
// Decodes the A/B outputs of a 2-bit up/down counter into step/dir pulses,
// a wrapping signed position and a saturating illegal-jump counter with fault.
module count_decoder
  import count_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a,
  input  logic                 b,
  input  logic                 clear,
  output logic                 locked,
  output logic                 step,
  output logic                 dir,
  output logic [WIDTH-1:0]     pos,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 fault
);

  fsm_state_t           r_state;
  cnt_state_t           r_prev;
  logic                 r_locked;
  logic                 r_step;
  logic                 r_dir;
  logic [WIDTH-1:0]     r_pos;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_fault;

  cnt_state_t           w_cur;
  step_cls_t            w_cls;
  logic [ERR_CNT_W-1:0] w_err_cnt_inc;

  assign w_cur = {a, b};

  step_classify u_step_classify (
    .i_prev  (r_prev),
    .i_cur   (w_cur),
    .o_cls_c (w_cls)
  );

  // Saturating increment used only on an illegal jump.
  assign w_err_cnt_inc = (r_err_cnt == ERR_CNT_MAX) ? r_err_cnt
                                                    : r_err_cnt + ERR_CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= UNLOCKED;
      r_prev    <= '0;
      r_locked  <= 1'b0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_pos     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      r_prev <= w_cur;
      case (r_state)
        UNLOCKED: begin
          r_state  <= LOCKED;
          r_locked <= 1'b1;
        end
        LOCKED: begin
          case (w_cls)
            UP: begin
              r_step <= 1'b1;
              r_dir  <= 1'b1;
              r_pos  <= r_pos + WIDTH'(1);
            end
            DOWN: begin
              r_step <= 1'b1;
              r_dir  <= 1'b0;
              r_pos  <= r_pos - WIDTH'(1);
            end
            ILLEGAL: begin
              r_err     <= 1'b1;
              r_err_cnt <= w_err_cnt_inc;
              if (w_err_cnt_inc >= ERR_CNT_W'(ERR_LIMIT)) r_fault <= 1'b1;
            end
            default: ;
          endcase
        end
        default: r_state <= UNLOCKED;
      endcase
      // Clear overrides any same-edge accumulator update; pulses still fire.
      if (clear) begin
        r_pos     <= '0;
        r_err_cnt <= '0;
        r_fault   <= 1'b0;
      end
    end
  end

  assign locked  = r_locked;
  assign step    = r_step;
  assign dir     = r_dir;
  assign pos     = r_pos;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign fault   = r_fault;

endmodule

// File: doc/count_decoder.md
# count_decoder

Receive-side companion to the 2-bit JK-based up/down counter. Samples the counter's two state bits each clock, recovers enable and direction, and accumulates a wide signed position. Flags illegal two-step jumps so a faulty or unsynchronised counter is detected. Sits directly on the counter's A/B outputs, in the same clock domain.

## Interface
- WIDTH, 8: width of the position accumulator.
- ERR_LIMIT, 3: error count at which `fault` asserts; legal range 1..15.

- clk  in  1  rising-edge clock, shared with the counter.
- reset  in  1  asynchronous, active-high reset.
- a  in  1  counter MSB (A).
- b  in  1  counter LSB (B).
- clear  in  1  synchronous clear of `pos`, `err_cnt` and `fault`.
- locked  out  1  high once a reference sample has been captured.
- step  out  1  one-cycle pulse: a legal ±1 transition was seen (recovered E).
- dir  out  1  last legal direction, 1 = up, 0 = down (recovered x).
- pos  out  WIDTH  position accumulator, two's-complement, wraps modulo 2^WIDTH.
- err  out  1  one-cycle pulse on an illegal ±2 transition.
- err_cnt  out  4  count of illegal transitions, saturates at 15.
- fault  out  1  sticky; high when err_cnt >= ERR_LIMIT.

## Operation
- Reset (async, active-high) forces all outputs and internal state to 0:
  - locked=0, step=0, dir=0, pos=0, err=0, err_cnt=0, fault=0, prev=2'b00.
- State machine with two states:
  - UNLOCKED: on the first clock edge, load prev<={a,b}, go to LOCKED, set locked=1. No step, err or pos change occurs on this edge.
  - LOCKED: each edge computes d = {a,b} - prev (mod 4) and loads prev<={a,b}.
- Action for each value of d:
  - d=0: hold. step=0, err=0; dir and pos unchanged.
  - d=1: up. step=1, dir=1, pos<=pos+1.
  - d=3: down. step=1, dir=0, pos<=pos-1.
  - d=2: illegal. err=1, err_cnt<=min(err_cnt+1,15); pos and dir unchanged; prev still updates, so the decoder resynchronises.
- `fault` sets on the edge where err_cnt becomes >= ERR_LIMIT. It stays set until `clear` or reset.
- `clear` (LOCKED or UNLOCKED):
  - Sets pos<=0, err_cnt<=0, fault<=0.
  - prev, locked and dir are unaffected.
  - Clear wins over a simultaneous step or err on the same edge: pos=0, err_cnt=0. The step and err pulses still fire for that edge.
- Wrap: pos increments from 2^WIDTH-1 to 0 and decrements from 0 to 2^WIDTH-1. No flag is raised.

## Timing
- All outputs are registered.
- Latency: a new {a,b} value present before edge k is reflected in step, dir, pos and err immediately after edge k. The counter's own output update is therefore seen one cycle after the counter's clock edge.
- step and err last exactly one cycle per transition and are never high together.
- Throughput: one transition per clock; back-to-back steps are all counted.
- Reset mid-operation: outputs clear immediately (asynchronous). The first edge after reset release is a lock-only edge.
- a and b are synchronous to clk; no synchroniser is included.

## Structure
- Shared package `count_pkg`:
  - 2-bit typedef for the counter state.
  - Enum for the step class: HOLD, UP, DOWN, ILLEGAL.
  - Enum for the FSM state: UNLOCKED, LOCKED.
  - Constant ERR_CNT_MAX=15.
- One sub-module, `step_classify`: combinational mapping of (prev, cur) to a step class. Instantiated once in `count_decoder`.
- `count_decoder` holds the FSM, the prev register, the accumulator, and the error/fault logic.

## Test plan
1. Reset, then hold {a,b}=00 for 3 cycles: locked=1 after the first edge; step=0, pos=0, err_cnt=0 throughout.
2. Drive 00,01,10,11,00,01: five step pulses, dir=1, pos=5.
3. From pos=5, drive 01,00,11,10: three step pulses, dir=0, pos=2.
4. With WIDTH=8 and pos=255, one up step gives pos=0. Then one down step gives pos=255.
5. Drive 00→10, 10→00, 00→10 with ERR_LIMIT=3:
   - Three err pulses; err_cnt=3; fault=1 after the third.
   - pos and dir unchanged.
   - A following clear gives err_cnt=0, fault=0.
6. Assert clear on the same edge as an up step from pos=7: step=1, dir=1, pos=0. Then assert reset mid-sequence: all outputs 0 immediately, and the next edge is lock-only.
